// File: rtl/shot_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shot_scheduler                                                |
// | Purpose  : Four-slot shared bullet pool. Arbitrates player/alien launch  |
// |            requests, steps flying slots on a movement tick and retires   |
// |            them on a hit or when they leave the playfield.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module shot_scheduler #(
   parameter int TICK_CYCLES    = 90000,
   parameter int COOLDOWN_TICKS = 3
) (
   input  logic        i_clk_36MHz,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_player_shoot,
   input  logic [4:0]  i_ship_x,
   input  logic        i_alien_shoot,
   input  logic [4:0]  i_alien_x,
   input  logic [3:0]  i_alien_y,
   input  logic [3:0]  i_hit,
   output logic        o_player_grant,
   output logic        o_alien_grant,
   output logic        o_tick,
   output logic [3:0]  o_slot_flying,
   output logic [3:0]  o_slot_dir,
   output logic [19:0] o_slot_x,
   output logic [15:0] o_slot_y
);

   localparam int CNT_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int COOL_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

   localparam logic [CNT_W-1:0]  c_cnt_last   = CNT_W'(TICK_CYCLES - 1);
   localparam logic [COOL_W-1:0] c_cool_load  = COOL_W'(COOLDOWN_TICKS);
   localparam logic [3:0]        c_player_row = 4'd12;
   localparam logic [3:0]        c_row_bottom = 4'd15;

   logic [CNT_W-1:0]  r_cnt;
   logic              r_tick;
   logic [COOL_W-1:0] r_cool;
   logic              r_pgrant;
   logic              r_agrant;
   logic [3:0]        r_flying;
   logic [3:0]        r_dir;
   logic [4:0]        r_x [4];
   logic [3:0]        r_y [4];

   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_step;
   logic              w_any_free;
   logic              w_player_out;
   logic              w_pgrant;
   logic              w_agrant;
   logic [1:0]        w_sel;

   // A tick only moves bullets while the playfield is enabled.
   assign w_step       = r_tick & i_enable;
   assign w_any_free   = ~&r_flying;
   assign w_player_out = |(r_flying & ~r_dir);

   // Launch arbitration from registered slot state; player has priority.
   assign w_pgrant = i_enable & i_player_shoot & ~w_player_out &
                     (r_cool == '0) & w_any_free;
   assign w_agrant = i_enable & i_alien_shoot & (i_alien_y != c_row_bottom) &
                     w_any_free & ~w_pgrant;

   // Next tick-counter value; frozen while disabled.
   always_comb begin
      w_cnt_next = r_cnt;
      if (i_enable) begin
         w_cnt_next = (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // Lowest-index free slot is the allocation target.
   always_comb begin
      w_sel = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (!r_flying[k]) w_sel = 2'(k);
      end
   end

   // Tick counter and registered tick pulse aligned with the last count.
   always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_tick <= i_enable && (w_cnt_next == c_cnt_last);
      end
   end

   // Grant pulses and player cooldown (load on launch, saturating decrement).
   always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_pgrant <= 1'b0;
         r_agrant <= 1'b0;
         r_cool   <= '0;
      end else begin
         r_pgrant <= w_pgrant;
         r_agrant <= w_agrant;
         if (w_pgrant) begin
            r_cool <= c_cool_load;
         end else if (w_step && (r_cool != '0)) begin
            r_cool <= r_cool - COOL_W'(1);
         end
      end
   end

   // Slot state: hit beats movement; free slots may only be loaded by a grant.
   always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_flying <= '0;
         r_dir    <= '0;
         for (int k = 0; k < 4; k++) begin
            r_x[k] <= '0;
            r_y[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (r_flying[k]) begin
               if (i_hit[k] ||
                   (w_step && !r_dir[k] && (r_y[k] == 4'd0)) ||
                   (w_step &&  r_dir[k] && (r_y[k] == c_row_bottom))) begin
                  r_flying[k] <= 1'b0;
                  r_dir[k]    <= 1'b0;
                  r_x[k]      <= '0;
                  r_y[k]      <= '0;
               end else if (w_step) begin
                  r_y[k] <= r_dir[k] ? r_y[k] + 4'd1 : r_y[k] - 4'd1;
               end
            end else if ((w_pgrant || w_agrant) && (w_sel == 2'(k))) begin
               r_flying[k] <= 1'b1;
               r_dir[k]    <= w_agrant;
               r_x[k]      <= w_pgrant ? i_ship_x : i_alien_x;
               r_y[k]      <= w_pgrant ? c_player_row : i_alien_y + 4'd1;
            end
         end
      end
   end

   assign o_player_grant = r_pgrant;
   assign o_alien_grant  = r_agrant;
   assign o_tick         = r_tick;
   assign o_slot_flying  = r_flying;
   assign o_slot_dir     = r_dir;

   for (genvar k = 0; k < 4; k++) begin : g_pack
      assign o_slot_x[5*k +: 5] = r_x[k];
      assign o_slot_y[4*k +: 4] = r_y[k];
   end

endmodule
`default_nettype wire
